// File: rtl/soc_system_onchip_dp_ram_pipe.sv
// rtl/soc_system_onchip_dp_ram_pipe.sv - true dual-port Avalon-MM RAM with pipelined reads
// Optional per-lane parity storage and checking when ONCHIP_RAM_PARITY_EN is defined.

module soc_system_onchip_dp_ram_pipe_rd #(
  parameter int W = 128,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clken,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [L-1:0] vld;
  logic [W-1:0] dat [L];

  // Data only moves behind a valid token, so the last stage holds the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < L; i++) dat[i] <= '0;
    end else if (clken) begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < L; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  // A frozen port must not replay its final-stage result on every stalled cycle.
  assign out_valid = vld[L-1] & clken;
  assign out_data  = dat[L-1];

endmodule

module soc_system_onchip_dp_ram_pipe #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1,
  parameter int BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ONCHIP_RAM_PARITY_EN
  input  logic              inject_err,
  output logic              parity_err_a,
  output logic              parity_err_b,
`endif
  input  logic              chipselect_a,
  input  logic              read_a,
  input  logic              write_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [BE_W-1:0]   byteenable_a,
  input  logic [DATA_W-1:0] writedata_a,
  input  logic              clken_a,
  output logic              waitrequest_a,
  output logic [DATA_W-1:0] readdata_a,
  output logic              readdatavalid_a,
  input  logic              chipselect_b,
  input  logic              read_b,
  input  logic              write_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [BE_W-1:0]   byteenable_b,
  input  logic [DATA_W-1:0] writedata_b,
  input  logic              clken_b,
  output logic              waitrequest_b,
  output logic [DATA_W-1:0] readdata_b,
  output logic              readdatavalid_b
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef ONCHIP_RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int RW = DATA_W + PW;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_conflict;
  logic              go_a, go_b;
  logic              in_a, in_b;
  logic              wen_a, wen_b;
  logic              ren_a, ren_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [RW-1:0]     pin_a, pin_b;
  logic [RW-1:0]     pout_a, pout_b;

  // Port A always wins a same-address write collision; B retries next cycle.
  assign wr_conflict   = chipselect_a & write_a & clken_a &
                         chipselect_b & write_b & (address_a == address_b);
  assign waitrequest_a = ~clken_a;
  assign waitrequest_b = ~clken_b | wr_conflict;

  assign go_a  = chipselect_a & (read_a | write_a) & clken_a & ~waitrequest_a;
  assign go_b  = chipselect_b & (read_b | write_b) & clken_b & ~waitrequest_b;
  assign in_a  = {1'b0, address_a} < DEPTH_L;
  assign in_b  = {1'b0, address_b} < DEPTH_L;
  assign idx_a = address_a[IDX_W-1:0];
  assign idx_b = address_b[IDX_W-1:0];

  assign wen_a = go_a & write_a & in_a & ~reset;
  assign wen_b = go_b & write_b & in_b & ~reset;
  assign ren_a = go_a & read_a & ~write_a;
  assign ren_b = go_b & read_b & ~write_b;

  // Reads sample the array before this edge's writes land: mixed-port RDW returns old data.
  assign rdata_a = in_a ? mem[idx_a] : '0;
  assign rdata_b = in_b ? mem[idx_b] : '0;

  always_ff @(posedge clk) begin
    if (wen_a) begin
      for (int i = 0; i < BE_W; i++)
        if (byteenable_a[i]) mem[idx_a][8*i +: 8] <= writedata_a[8*i +: 8];
    end
    if (wen_b) begin
      for (int i = 0; i < BE_W; i++)
        if (byteenable_b[i]) mem[idx_b][8*i +: 8] <= writedata_b[8*i +: 8];
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  logic [BE_W-1:0] par [DEPTH];
  logic            perr_a, perr_b;

  function automatic logic [BE_W-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] p;
    for (int i = 0; i < BE_W; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (wen_a) begin
      for (int i = 0; i < BE_W; i++)
        if (byteenable_a[i]) par[idx_a][i] <= (^writedata_a[8*i +: 8]) ^ inject_err;
    end
    if (wen_b) begin
      for (int i = 0; i < BE_W; i++)
        if (byteenable_b[i]) par[idx_b][i] <= (^writedata_b[8*i +: 8]) ^ inject_err;
    end
  end

  assign perr_a = in_a & (|(byteenable_a & (par[idx_a] ^ lane_parity(rdata_a))));
  assign perr_b = in_b & (|(byteenable_b & (par[idx_b] ^ lane_parity(rdata_b))));
  assign pin_a  = {perr_a, rdata_a};
  assign pin_b  = {perr_b, rdata_b};
  assign parity_err_a = pout_a[DATA_W] & readdatavalid_a;
  assign parity_err_b = pout_b[DATA_W] & readdatavalid_b;
`else
  assign pin_a = rdata_a;
  assign pin_b = rdata_b;
`endif

  soc_system_onchip_dp_ram_pipe_rd #(.W(RW), .L(READ_LATENCY)) u_rd_a (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken_a),
    .in_valid  (ren_a),
    .in_data   (pin_a),
    .out_valid (readdatavalid_a),
    .out_data  (pout_a)
  );

  soc_system_onchip_dp_ram_pipe_rd #(.W(RW), .L(READ_LATENCY)) u_rd_b (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken_b),
    .in_valid  (ren_b),
    .in_data   (pin_b),
    .out_valid (readdatavalid_b),
    .out_data  (pout_b)
  );

  assign readdata_a = pout_a[DATA_W-1:0];
  assign readdata_b = pout_b[DATA_W-1:0];

endmodule

// File: doc/soc_system_onchip_dp_ram_pipe.md
Name: soc_system_onchip_dp_ram_pipe

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports (s1 = port A, s2 = port B), generalised in width and depth.
- Adds features the current memory lacks:
  - pipelined, configurable read latency with readdatavalid;
  - defined collision handling via waitrequest;
  - defined mixed-port read-during-write.
- Sits between the HPS/fabric interconnect and the accelerator datapath as shared scratch memory.

Parameters:
- DATA_W, 128, data width per port; must be a multiple of 8.
- ADDR_W, 10, word address width.
- DEPTH, 64, number of implemented words; must be ≤ 2**ADDR_W.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal 1..3.
- BE_W, DATA_W/8, byteenable width (derived; not overridden).

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-high reset.
- chipselect_a / chipselect_b  in  1  port select.
- read_a / read_b  in  1  read request.
- write_a / write_b  in  1  write request.
- address_a / address_b  in  ADDR_W  word address.
- byteenable_a / byteenable_b  in  BE_W  byte lane enables for writes.
- writedata_a / writedata_b  in  DATA_W  write data.
- clken_a / clken_b  in  1  per-port clock enable; low stalls the port.
- waitrequest_a / waitrequest_b  out  1  command not accepted this cycle.
- readdata_a / readdata_b  out  DATA_W  read data.
- readdatavalid_a / readdatavalid_b  out  1  readdata valid this cycle.

Behaviour:
- Reset values: readdata 0, readdatavalid 0, waitrequest 0, read pipeline flushed. RAM contents are not cleared.
- Reset asserted mid-operation: in-flight reads are discarded and no readdatavalid is issued for them. Any write in the reset cycle is dropped.
- Command acceptance: a command is accepted when chipselect & (read|write) & clken & ~waitrequest at the rising edge.
  - read and write high together on one port: the write takes effect; no read is issued.
- Waitrequest:
  - Combinational; high when clken is low.
  - Port B only: also high when both ports present a write to the same address in the same cycle. Port A always wins.
  - Stalled master holds its command; it is accepted on the next cycle if no new conflict.
- Writes: only byte lanes with byteenable=1 update; the other lanes keep their old value.
- Read latency: readdatavalid pulses exactly READ_LATENCY cycles after acceptance, for one cycle, with the matching readdata.
  - Back-to-back reads sustain one result per cycle.
  - readdata holds its last value when readdatavalid is low.
- Clock enable: clken low freezes that port's read pipeline (valid and data hold, no advance). The other port is unaffected.
- Same-port read-during-write cannot occur (write has priority).
- Mixed-port read-during-write: port X reads address N while port Y writes N in the same cycle → read returns OLD data. This is required, not don't-care.
- Out-of-range address (address ≥ DEPTH):
  - write is accepted and dropped;
  - read is accepted and returns 0 with normal readdatavalid timing.

Optional Feature:
- Macro ONCHIP_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with the data.
  - Extra outputs parity_err_a / parity_err_b (1 bit each, reset 0). Each pulses high together with readdatavalid when any enabled lane's stored parity mismatches the data read.
  - Out-of-range reads never flag an error.
  - Extra input inject_err (1 bit): while high, written parity is inverted.
- Undefined: no parity storage, and none of these ports exist.

Test Plan:
- Reset, then port A writes 0x0123…EF to addr 5 with all byteenables; port B reads addr 5 → readdatavalid_b exactly READ_LATENCY cycles after acceptance, with that data.
- Write 0xFF..FF to addr 3, then write 0x00..00 with byteenable=0x0001 → read returns 0xFF..FF00.
- Both ports write addr 7 in the same cycle (A=0xAA.., B=0x55..) → waitrequest_b high one cycle; final content is 0x55.. (B lands second); no lost write.
- Port A writes addr 9 with 0x11.. while port B reads addr 9 (old 0x22..) in the same cycle → B returns 0x22..; the next read returns 0x11...
- READ_LATENCY=3, four back-to-back reads; clken_b low for 2 cycles mid-stream → four valid pulses in order, delayed by exactly 2 cycles; reset asserted with reads in flight → no further readdatavalid.
- With ONCHIP_RAM_PARITY_EN defined: write with inject_err=1, then read → parity_err pulses with readdatavalid. Read of address 64 (DEPTH=64) → data 0, parity_err 0.
